// File: rtl/dm_responder_pkg.sv
// Shared definitions for the data-memory responder.
// Holds the machine word width, the RV32I funct3 access-size codes used by
// loads and stores, and the responder FSM state encoding.
package dm_responder_pkg;

    localparam int XLEN = 32;

    // funct3 codes for loads and stores (the U variants exist only for loads)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dm_state_e;

endpackage

// File: rtl/dm_lane_align.sv
// Combinational byte-lane steering for the data-memory responder.
// Store path: builds a byte-enable mask and lane-replicated write data from
// the low address bits and funct3. Load path: selects the addressed byte or
// half of a memory word and sign/zero extends it. The fault output flags a
// misaligned access or an funct3 code that is undefined for the access kind.
//   is_store        : 1 = store access, 0 = load access
//   addr_lo         : byte offset within the word
//   f3              : RV32I funct3 of the access
//   st_data         : right-aligned store data
//   ld_word         : memory word being loaded from
//   st_mask         : byte-lane write enables
//   st_data_aligned : store data placed on its lanes
//   ld_data         : extended load result
//   fault           : misaligned or undefined access
module dm_lane_align
    import dm_responder_pkg::*;
(
    input  logic            is_store,
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      f3,
    input  logic [XLEN-1:0] st_data,
    input  logic [XLEN-1:0] ld_word,
    output logic [3:0]      st_mask,
    output logic [XLEN-1:0] st_data_aligned,
    output logic [XLEN-1:0] ld_data,
    output logic            fault
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store data is replicated onto every lane so only the mask has to
    // depend on the offset; the RAM ignores lanes whose enable is low.
    always_comb begin
        st_mask         = 4'b0000;
        st_data_aligned = '0;
        ld_data         = '0;
        fault           = 1'b0;
        ld_byte         = ld_word[{addr_lo, 3'b000} +: 8];
        ld_half         = addr_lo[1] ? ld_word[31:16] : ld_word[15:0];

        if (is_store) begin
            case (f3)
                F3_B: begin
                    st_mask         = 4'b0001 << addr_lo;
                    st_data_aligned = {4{st_data[7:0]}};
                end
                F3_H: begin
                    fault           = addr_lo[0];
                    st_mask         = addr_lo[1] ? 4'b1100 : 4'b0011;
                    st_data_aligned = {2{st_data[15:0]}};
                end
                F3_W: begin
                    fault           = (addr_lo != 2'b00);
                    st_mask         = 4'b1111;
                    st_data_aligned = st_data;
                end
                default: fault = 1'b1;
            endcase
        end else begin
            case (f3)
                F3_B:  ld_data = {{24{ld_byte[7]}}, ld_byte};
                F3_BU: ld_data = {24'b0, ld_byte};
                F3_H: begin
                    fault   = addr_lo[0];
                    ld_data = {{16{ld_half[15]}}, ld_half};
                end
                F3_HU: begin
                    fault   = addr_lo[0];
                    ld_data = {16'b0, ld_half};
                end
                F3_W: begin
                    fault   = (addr_lo != 2'b00);
                    ld_data = ld_word;
                end
                default: fault = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/dm_responder.sv
// Data-memory target for the hart load/store port, backed by a word-organised
// RAM. A request is captured in IDLE, held for LATENCY wait states and
// answered with a one-cycle ready pulse carrying the load result or a fault.
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_DM_MemRead      : read request, held until o_DM_data_ready
//   i_DM_Wen          : write request, held until o_DM_data_ready
//   i_DM_Addr         : byte address
//   i_DM_WriteData    : right-aligned store data
//   i_DM_f3           : access size/sign (RV32I funct3)
//   o_DM_data_ready   : one-cycle completion pulse
//   o_DM_ReadData     : load result, zero outside the ready cycle
//   o_DM_err          : access fault, valid with o_DM_data_ready
module dm_responder
    import dm_responder_pkg::*;
#(
    parameter int          MEM_WORDS = 1024,
    parameter int          LATENCY   = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_DM_MemRead,
    input  logic            i_DM_Wen,
    input  logic [31:0]     i_DM_Addr,
    input  logic [XLEN-1:0] i_DM_WriteData,
    input  logic [2:0]      i_DM_f3,
    output logic            o_DM_data_ready,
    output logic [XLEN-1:0] o_DM_ReadData,
    output logic            o_DM_err
);

    localparam int          AW   = $clog2(MEM_WORDS);
    localparam logic [32:0] SPAN = 33'(MEM_WORDS) << 2;

    dm_state_e       state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [31:0]     addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [2:0]      f3_q, f3_d;
    logic            store_q, store_d;
    logic [XLEN-1:0] ld_q, ld_d;
    logic            err_q, err_d;

    logic [XLEN-1:0] mem [MEM_WORDS];

    logic            req;
    logic            capturing;
    logic [31:0]     sel_addr;
    logic [XLEN-1:0] sel_wdata;
    logic [2:0]      sel_f3;
    logic            sel_store;
    logic [31:0]     offset;
    logic            in_range;
    logic [AW-1:0]   word_idx;
    logic [XLEN-1:0] rd_word;
    logic [3:0]      st_mask;
    logic [XLEN-1:0] st_data_aligned;
    logic [XLEN-1:0] ld_data;
    logic            lane_fault;
    logic            fault_now;
    logic            mem_we;

    // While idle the live request fields drive the address/lane logic so the
    // word can be read and checked at capture; afterwards the captured copies
    // drive it so the write commits with the values seen at capture.
    always_comb begin
        req       = i_DM_MemRead | i_DM_Wen;
        capturing = (state_q == IDLE);
        sel_addr  = capturing ? i_DM_Addr      : addr_q;
        sel_wdata = capturing ? i_DM_WriteData : wdata_q;
        sel_f3    = capturing ? i_DM_f3        : f3_q;
        sel_store = capturing ? i_DM_Wen       : store_q;
        offset    = sel_addr - BASE_ADDR;
        in_range  = (sel_addr >= BASE_ADDR) && ({1'b0, offset} < SPAN);
        word_idx  = offset[AW+1:2];
        rd_word   = mem[word_idx];
        fault_now = capturing ? (lane_fault | ~in_range | (i_DM_MemRead & i_DM_Wen))
                              : err_q;
    end

    dm_lane_align u_lane_align (
        .is_store        (sel_store),
        .addr_lo         (sel_addr[1:0]),
        .f3              (sel_f3),
        .st_data         (sel_wdata),
        .ld_word         (rd_word),
        .st_mask         (st_mask),
        .st_data_aligned (st_data_aligned),
        .ld_data         (ld_data),
        .fault           (lane_fault)
    );

    // Next-state logic. The RAM write is issued on the transition into RESP,
    // so a request that disappears during WAIT never reaches memory.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        store_d = store_q;
        ld_d    = ld_q;
        err_d   = err_q;
        mem_we  = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = i_DM_Addr;
                    wdata_d = i_DM_WriteData;
                    f3_d    = i_DM_f3;
                    store_d = i_DM_Wen;
                    err_d   = fault_now;
                    ld_d    = (fault_now | i_DM_Wen) ? '0 : ld_data;
                    if (LATENCY == 0) begin
                        state_d = RESP;
                        mem_we  = i_DM_Wen & ~fault_now;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(LATENCY);
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = RESP;
                        mem_we  = store_q & ~err_q;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= 3'b000;
            store_q <= 1'b0;
            ld_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            store_q <= store_d;
            ld_q    <= ld_d;
            err_q   <= err_d;
        end
    end

    // RAM contents survive reset; only an in-flight write is suppressed.
    always_ff @(posedge i_clk) begin
        if (mem_we && !i_rst) begin
            for (int i = 0; i < 4; i++) begin
                if (st_mask[i]) begin
                    mem[word_idx][8*i +: 8] <= st_data_aligned[8*i +: 8];
                end
            end
        end
    end

    assign o_DM_data_ready = (state_q == RESP);
    assign o_DM_ReadData   = o_DM_data_ready ? ld_q : '0;
    assign o_DM_err        = o_DM_data_ready & err_q;

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder. Two instances with different latency, base and
// depth are exercised one after the other; a transaction-level model of the
// memory predicts when each ready pulse must occur and what it must carry.
module tb_dm_responder;
   import dm_responder_pkg::*;

   logic        clk;
   logic        rst     [2];
   logic        memRead [2];
   logic        wen     [2];
   logic [31:0] addrIn  [2];
   logic [31:0] wdIn    [2];
   logic [2:0]  f3In    [2];
   logic        ready   [2];
   logic        errO    [2];
   logic [31:0] rdataO  [2];

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   bit          checkOn = 0;

   bit          expValid [2];
   int          expCycle [2];
   logic [31:0] expData  [2];
   logic        expErr   [2];
   int          capCycle [2];
   logic [31:0] capData  [2];
   logic        capErr   [2];
   bit          respPending [2];
   logic [31:0] modelMem [2][8];
   logic [31:0] lastModelData;
   int          issueCycle;

   dm_responder #(.MEM_WORDS(1024), .LATENCY(1), .BASE_ADDR(32'h0000_0000)) dut0 (
      .i_clk(clk), .i_rst(rst[0]), .i_DM_MemRead(memRead[0]), .i_DM_Wen(wen[0]),
      .i_DM_Addr(addrIn[0]), .i_DM_WriteData(wdIn[0]), .i_DM_f3(f3In[0]),
      .o_DM_data_ready(ready[0]), .o_DM_ReadData(rdataO[0]), .o_DM_err(errO[0]));

   dm_responder #(.MEM_WORDS(64), .LATENCY(3), .BASE_ADDR(32'h0000_2000)) dut1 (
      .i_clk(clk), .i_rst(rst[1]), .i_DM_MemRead(memRead[1]), .i_DM_Wen(wen[1]),
      .i_DM_Addr(addrIn[1]), .i_DM_WriteData(wdIn[1]), .i_DM_f3(f3In[1]),
      .o_DM_data_ready(ready[1]), .o_DM_ReadData(rdataO[1]), .o_DM_err(errO[1]));

   initial clk = 0;
   always #5 clk = ~clk;

   function automatic int getLat(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   function automatic longint getBase(input int d);
      return (d == 0) ? 64'h0 : 64'h2000;
   endfunction

   function automatic longint getWords(input int d);
      return (d == 0) ? 1024 : 64;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, got, want);
      end
   endtask

   // Memory model: works in bytes and integer arithmetic on a small window of
   // words, deciding faults, the load value and the updated word.
   task automatic modelAccess(input int d, input bit rd, input bit wr, input logic [31:0] a,
                              input logic [31:0] wd, input logic [2:0] f3,
                              output bit err, output logic [31:0] rdata,
                              output logic [31:0] nword, output bit doWrite, output int idx);
      longint off;
      longint v;
      int     size;
      int     b;
      bit     legal;
      logic [31:0] word;
      off = longint'({32'd0, a}) - getBase(d);
      b = int'(a & 32'd3);
      legal = 1;
      size = 1;
      case (f3)
         3'd0, 3'd4: size = 1;
         3'd1, 3'd5: size = 2;
         3'd2:       size = 4;
         default:    legal = 0;
      endcase
      if (wr && f3[2]) legal = 0;
      err = (rd && wr) || !legal || (off < 0) || (off >= 4 * getWords(d)) || ((b % size) != 0);
      idx = err ? 0 : int'(off / 4);
      word = modelMem[d][idx];
      rdata = 32'h0;
      nword = word;
      doWrite = 0;
      if (!err && rd) begin
         v = 0;
         for (int i = 0; i < size; i++) v = v | (longint'(word[8*(b+i) +: 8]) << (8*i));
         if (!f3[2] && size < 4 && v >= (longint'(1) << (8*size - 1))) v = v - (longint'(1) << (8*size));
         rdata = v[31:0];
      end
      if (!err && wr) begin
         for (int i = 0; i < size; i++) nword[8*(b+i) +: 8] = wd[8*i +: 8];
         doWrite = 1;
      end
   endtask

   // Drives one complete transaction, scrambling the fields while it waits,
   // and leaves the request asserted through the ready cycle.
   task automatic applyStimulus(input int d, input bit rd, input bit wr, input logic [31:0] a,
                                input logic [31:0] wd, input logic [2:0] f3);
      bit err, doWrite;
      logic [31:0] rdata, nword;
      int idx, start;
      modelAccess(d, rd, wr, a, wd, f3, err, rdata, nword, doWrite, idx);
      start = cyc + (respPending[d] ? 1 : 0);
      memRead[d] = rd; wen[d] = wr; addrIn[d] = a; wdIn[d] = wd; f3In[d] = f3;
      expCycle[d] = start + 1 + getLat(d);
      expData[d] = rdata;
      expErr[d] = err;
      expValid[d] = 1;
      lastModelData = rdata;
      issueCycle = start;
      do begin
         @(negedge clk);
         if (cyc >= start + 1 && cyc <= start + getLat(d)) begin
            addrIn[d] = $urandom; wdIn[d] = $urandom; f3In[d] = 3'($urandom);
         end
      end while (cyc < expCycle[d]);
      if (doWrite) modelMem[d][idx] = nword;
      respPending[d] = 1;
   endtask

   // Starts a transaction and kills it k cycles into its wait, either by
   // reset or by dropping the request; no ready and no write may follow.
   task automatic abortStimulus(input int d, input bit rd, input bit wr, input logic [31:0] a,
                                input logic [31:0] wd, input logic [2:0] f3,
                                input bit useReset, input int k);
      int start;
      start = cyc + (respPending[d] ? 1 : 0);
      expValid[d] = 0;
      memRead[d] = rd; wen[d] = wr; addrIn[d] = a; wdIn[d] = wd; f3In[d] = f3;
      while (cyc < start + k) @(negedge clk);
      if (useReset) rst[d] = 1;
      else begin
         memRead[d] = 0; wen[d] = 0;
      end
      @(negedge clk);
      rst[d] = 0; memRead[d] = 0; wen[d] = 0;
      respPending[d] = 0;
   endtask

   task automatic idleCycles(input int d, input int n);
      memRead[d] = 0; wen[d] = 0;
      if (n > 0) begin
         repeat (n) @(negedge clk);
         respPending[d] = 0;
      end
   endtask

   task automatic expectResult(input int d, input string tag, input logic [31:0] wantData, input logic wantErr);
      checkOutput({tag, "_data"}, capData[d], wantData);
      checkOutput({tag, "_err"}, {31'b0, capErr[d]}, {31'b0, wantErr});
      checkOutput({tag, "_model"}, lastModelData, wantData);
      checkOutput({tag, "_latency"}, capCycle[d] - issueCycle, getLat(d) + 1);
   endtask

   // Every cycle, after the edge has settled, each DUT is held against the
   // model's prediction of whether a pulse is due and what it carries.
   always begin
      bit          expR;
      logic [31:0] expD;
      logic        expE;
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      if (checkOn) begin
         for (int d = 0; d < 2; d++) begin
            expR = expValid[d] && (cyc == expCycle[d]);
            expD = expR ? expData[d] : 32'h0;
            expE = expR ? expErr[d] : 1'b0;
            checkOutput($sformatf("dut%0d_ready@%0d", d, cyc), {31'b0, ready[d]}, {31'b0, expR});
            checkOutput($sformatf("dut%0d_rdata@%0d", d, cyc), rdataO[d], expD);
            checkOutput($sformatf("dut%0d_err@%0d", d, cyc), {31'b0, errO[d]}, {31'b0, expE});
            if (ready[d] === 1'b1) begin
               capCycle[d] = cyc;
               capData[d] = rdataO[d];
               capErr[d] = errO[d];
            end
         end
      end
   end

   task automatic randomPhase(input int d, input int n);
      logic [2:0] legalF3 [5];
      logic [31:0] a;
      logic [2:0] f3;
      int r, p;
      bit rd, wr;
      legalF3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      for (int t = 0; t < n; t++) begin
         r = $urandom_range(0, 99);
         p = $urandom_range(0, 9);
         if (p == 0) a = 32'(getBase(d) + 4 * getWords(d)) + $urandom_range(0, 15);
         else if (p == 1) a = 32'(getBase(d)) - $urandom_range(1, 16);
         else a = 32'(getBase(d)) + $urandom_range(0, 31);
         f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : legalF3[$urandom_range(0, 4)];
         if (r < 8) begin
            abortStimulus(d, r[0], !r[0], a, $urandom, f3, r[1], $urandom_range(1, getLat(d)));
         end else begin
            rd = (r < 54) || (r >= 92);
            wr = (r >= 54);
            applyStimulus(d, rd, wr, a, $urandom, f3);
         end
         idleCycles(d, $urandom_range(0, 2));
      end
   endtask

   initial begin
      int c1, c2, c3;
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1; memRead[d] = 0; wen[d] = 0;
         addrIn[d] = 0; wdIn[d] = 0; f3In[d] = 0;
         expValid[d] = 0; expCycle[d] = 0; respPending[d] = 0;
         capCycle[d] = 0; capData[d] = 0; capErr[d] = 0;
      end
      repeat (2) @(negedge clk);
      checkOn = 1;
      @(negedge clk);
      checkOutput("reset_ready0", {31'b0, ready[0]}, 32'h0);
      checkOutput("reset_rdata1", rdataO[1], 32'h0);
      rst[0] = 0; rst[1] = 0;
      @(negedge clk);

      for (int d = 0; d < 2; d++) begin
         for (int w = 0; w < 8; w++) applyStimulus(d, 0, 1, 32'(getBase(d)) + 32'(4*w), $urandom, F3_W);
         idleCycles(d, 1);
      end

      applyStimulus(0, 0, 1, 32'h10, 32'hDEADBEEF, F3_W);   expectResult(0, "sw_deadbeef", 32'h0, 0);
      idleCycles(0, 1);
      applyStimulus(0, 1, 0, 32'h10, 32'h0, F3_W);           expectResult(0, "lw_deadbeef", 32'hDEADBEEF, 0);
      idleCycles(0, 1);
      applyStimulus(0, 0, 1, 32'h10, 32'h11223344, F3_W);
      applyStimulus(0, 0, 1, 32'h13, 32'hFFFFFF80, F3_B);
      applyStimulus(0, 1, 0, 32'h10, 32'h0, F3_W);           expectResult(0, "lw_after_sb", 32'h80223344, 0);
      applyStimulus(0, 1, 0, 32'h13, 32'h0, F3_B);           expectResult(0, "lb_13", 32'hFFFFFF80, 0);
      applyStimulus(0, 1, 0, 32'h13, 32'h0, F3_BU);          expectResult(0, "lbu_13", 32'h00000080, 0);
      applyStimulus(0, 0, 1, 32'h10, 32'h80017FFF, F3_W);
      applyStimulus(0, 1, 0, 32'h12, 32'h0, F3_H);           expectResult(0, "lh_12", 32'hFFFF8001, 0);
      applyStimulus(0, 1, 0, 32'h10, 32'h0, F3_HU);          expectResult(0, "lhu_10", 32'h00007FFF, 0);
      applyStimulus(0, 1, 0, 32'h11, 32'h0, F3_W);           expectResult(0, "lw_misaligned", 32'h0, 1);
      applyStimulus(0, 0, 1, 32'h13, 32'h5555, F3_H);        expectResult(0, "sh_misaligned", 32'h0, 1);
      applyStimulus(0, 1, 0, 32'h10, 32'h0, F3_W);           expectResult(0, "lw_unchanged", 32'h80017FFF, 0);
      applyStimulus(0, 1, 0, 32'h1000, 32'h0, F3_W);         expectResult(0, "lw_out_of_range", 32'h0, 1);
      applyStimulus(0, 0, 1, 32'h1000, 32'hFFFFFFFF, F3_W);  expectResult(0, "sw_out_of_range", 32'h0, 1);
      applyStimulus(0, 1, 1, 32'h10, 32'h0, F3_W);           expectResult(0, "both_high", 32'h0, 1);
      applyStimulus(0, 1, 0, 32'h10, 32'h0, 3'b011);         expectResult(0, "load_f3_011", 32'h0, 1);
      applyStimulus(0, 0, 1, 32'h10, 32'h0, F3_BU);          expectResult(0, "store_f3_100", 32'h0, 1);
      applyStimulus(0, 1, 0, 32'h0, 32'h0, F3_W);
      idleCycles(0, 1);

      applyStimulus(1, 0, 1, 32'h2000, 32'h11111111, F3_W);
      applyStimulus(1, 0, 1, 32'h2004, 32'h22222222, F3_W);
      applyStimulus(1, 0, 1, 32'h2008, 32'h33333333, F3_W);
      idleCycles(1, 1);
      applyStimulus(1, 1, 0, 32'h2000, 32'h0, F3_W);         expectResult(1, "b2b_lw0", 32'h11111111, 0);
      c1 = capCycle[1];
      applyStimulus(1, 1, 0, 32'h2004, 32'h0, F3_W);         c2 = capCycle[1];
      checkOutput("b2b_lw1_data", capData[1], 32'h22222222);
      applyStimulus(1, 1, 0, 32'h2008, 32'h0, F3_W);         c3 = capCycle[1];
      checkOutput("b2b_lw2_data", capData[1], 32'h33333333);
      checkOutput("b2b_spacing_a", c2 - c1, 5);
      checkOutput("b2b_spacing_b", c3 - c2, 5);
      idleCycles(1, 1);
      abortStimulus(1, 0, 1, 32'h2004, 32'hBADBAD00, F3_W, 1, 2);
      idleCycles(1, 1);
      applyStimulus(1, 1, 0, 32'h2004, 32'h0, F3_W);         expectResult(1, "after_reset_abort", 32'h22222222, 0);
      idleCycles(1, 1);
      abortStimulus(1, 0, 1, 32'h2004, 32'hBADBAD01, F3_W, 0, 3);
      applyStimulus(1, 1, 0, 32'h2004, 32'h0, F3_W);         expectResult(1, "after_drop_abort", 32'h22222222, 0);
      applyStimulus(1, 1, 0, 32'h2100, 32'h0, F3_W);         expectResult(1, "lw_top_edge", 32'h0, 1);
      applyStimulus(1, 1, 0, 32'h1FFC, 32'h0, F3_W);         expectResult(1, "lw_below_base", 32'h0, 1);
      idleCycles(1, 1);

      randomPhase(0, 200);
      idleCycles(0, 2);
      randomPhase(1, 200);
      idleCycles(1, 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
